// File: rtl/crypto0_block_decryptor.sv
// Receive-side crypto0 block decryptor: strips the low-half load mask, then
// undoes the XOR round chain by applying the rotated round keys in reverse.
module crypto0_block_decryptor #(
    parameter int ROUND_COUNT = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] ciphertext,
    input  logic [127:0] cipher_key,
    input  logic [63:0]  load_mask,
    input  logic         decrypt_start,
    output logic [127:0] plaintext,
    output logic         decrypt_done,
    output logic         busy
);

    localparam int CW = $clog2(ROUND_COUNT);
    localparam int START_ROT = (8 * (ROUND_COUNT - 2)) % 128;
    localparam logic [CW-1:0] LAST_CNT = CW'(ROUND_COUNT - 1);

    typedef enum logic {
        IDLE,
        RUN
    } phase_t;

    phase_t          phase;
    logic [127:0]    state;
    logic [127:0]    round_key;
    logic [CW-1:0]   round_cnt;
    logic [127:0]    start_key;

    // Last key the encryptor used; a zero rotation degenerates cleanly since
    // a 128-bit shift by 128 yields zero.
    assign start_key = (cipher_key << START_ROT) | (cipher_key >> (128 - START_ROT));

    always_ff @(posedge clk) begin
        if (rst) begin
            phase        <= IDLE;
            state        <= '0;
            round_key    <= '0;
            round_cnt    <= '0;
            busy         <= 1'b0;
            plaintext    <= '0;
            decrypt_done <= 1'b0;
        end else begin
            case (phase)
                IDLE: begin
                    decrypt_done <= 1'b0;
                    if (decrypt_start) begin
                        state     <= ciphertext ^ {64'h0, load_mask};
                        round_key <= start_key;
                        round_cnt <= '0;
                        busy      <= 1'b1;
                        phase     <= RUN;
                    end
                end
                RUN: begin
                    if (round_cnt != LAST_CNT) begin
                        state     <= state ^ round_key;
                        round_key <= {round_key[7:0], round_key[127:8]};
                        round_cnt <= round_cnt + CW'(1);
                    end else begin
                        plaintext    <= state;
                        decrypt_done <= 1'b1;
                        busy         <= 1'b0;
                        phase        <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/crypto0_block_decryptor.md
# crypto0_block_decryptor

Receive-side counterpart of the crypto0 encryption host. It takes a 128-bit ciphertext block and the 128-bit cipher key and recovers the plaintext. It does this by removing the 64-bit low-half output mask and then undoing the XOR round chain, applying the rotated round keys in reverse order. It sits on the consumer side of the crypto0 link and uses the same start/done pulse handshake as the encryptor.

## Interface
- ROUND_COUNT, 8, round-count setting shared with the encryptor (legal: 2..16). ROUND_COUNT-1 XOR rounds are applied.
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- ciphertext  in  128  ciphertext block, sampled on the accepting edge
- cipher_key  in  128  key, sampled on the accepting edge
- load_mask  in  64  mask XORed into ciphertext[63:0] by the encryptor, sampled on the accepting edge
- decrypt_start  in  1  request; accepted only when busy=0
- plaintext  out  128  recovered block, registered; holds until the next completion
- decrypt_done  out  1  one-cycle pulse when plaintext updates
- busy  out  1  high while a block is in progress

## Operation
- Registers: state[127:0], round_key[127:0], round_cnt[$clog2(ROUND_COUNT)-1:0], busy, plaintext, decrypt_done.
- State machine has two states, IDLE (busy=0) and RUN (busy=1).
- **IDLE, decrypt_start=1:**
  - state <= ciphertext ^ {64'h0, load_mask}.
  - round_key <= rotl(cipher_key, 8*(ROUND_COUNT-2) mod 128), i.e. the last round key the encryptor used.
  - round_cnt <= 0; busy <= 1.
- **IDLE, decrypt_start=0:** nothing changes except decrypt_done <= 0.
- **RUN, round_cnt != ROUND_COUNT-1:**
  - state <= state ^ round_key.
  - round_key <= rotr(round_key, 8), i.e. {round_key[7:0], round_key[127:8]}.
  - round_cnt <= round_cnt + 1.
- **RUN, round_cnt == ROUND_COUNT-1:** plaintext <= state; decrypt_done <= 1; busy <= 0; state is unchanged.
- decrypt_start while busy=1 is ignored. No queuing; inputs presented then are not captured.
- Inputs may change freely after the accepting edge.
- All arithmetic is 128-bit XOR/rotate. round_cnt increments modulo its width and never wraps in legal use.
- The mask applies only to bits [63:0]; bits [127:64] are never masked.

## Timing
- Reset state: plaintext=0, decrypt_done=0, busy=0, state=0, round_key=0, round_cnt=0.
- Reset has priority over every other input in the same cycle.
- Reset asserted mid-block aborts it: no done pulse, plaintext returns to 0, the next start behaves as from power-up.
- Block accepted at edge T:
  - busy=1 from T through T+ROUND_COUNT-1.
  - Rounds are applied at edges T+1 .. T+ROUND_COUNT-1.
  - At edge T+ROUND_COUNT, plaintext is valid and decrypt_done=1 for exactly one cycle.
  - Latency start->done is ROUND_COUNT cycles (8 at default).
- decrypt_start sampled at edge T+ROUND_COUNT is ignored because busy was still 1. The earliest next accept is edge T+ROUND_COUNT+1, giving a throughput of one block per ROUND_COUNT+1 cycles.
- decrypt_done falls at the edge after it rises, regardless of decrypt_start.

## Test plan
- Reset check: assert rst for 2 cycles with decrypt_start held high -> plaintext=0, decrypt_done=0, busy=0. Release, keep start high -> block accepted on the first edge after release; busy rises, done pulses 8 cycles later.
- Identity: key=0, mask=0, ciphertext=128'h0123456789ABCDEF_FEDCBA9876543210 -> plaintext equals ciphertext; done exactly 8 cycles after the accepting edge.
- Uniform key: key={16{8'hA5}}, mask=0, ciphertext=0. All rotations are equal and 7 rounds is odd, so plaintext={16{8'hA5}}.
- Mask removal: key=0, ciphertext=0, load_mask=64'hDEADBEEF_CAFEF00D -> plaintext=128'h0000000000000000_DEADBEEFCAFEF00D.
- Round trip: feed the crypto0 encryptor's ciphertext and trojan load (as load_mask) for plaintext=128'h00112233445566778899AABBCCDDEEFF, key=128'h000102030405060708090A0B0C0D0E0F -> the original plaintext is recovered. Also sweep ROUND_COUNT=2 and 16.
- Busy and abort:
  - Pulse start at T+3 and at T+8 -> both ignored, exactly one done pulse at T+8.
  - Assert rst at T+4 -> no done pulse, busy=0, plaintext=0.
  - Next start after the abort -> correct result.
